// File: rtl/wb_sram16_bridge.sv
// Wishbone classic slave that turns 32-bit CPU accesses into one or two timed
// halfword cycles on a 16-bit asynchronous SRAM (low half first, sel-gated).
// Every output is registered and reflects the state being entered, so pin
// timing lines up cycle-for-cycle with the FSM state.
module wb_sram16_bridge #(
    parameter int ADR_W       = 19,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    input  logic [3:0]       wb_sel_i,
    input  logic             wb_we_i,
    input  logic             wb_stb_i,
    input  logic             wb_cyc_i,
    output logic             wb_ack_o,
    output logic [ADR_W-1:0] sram_adr,
    output logic [15:0]      sram_dat_o,
    input  logic [15:0]      sram_dat_i,
    output logic             sram_dat_oe,
    output logic [1:0]       sram_be_n,
    output logic             sram_ce_n,
    output logic             sram_oe_n,
    output logic             sram_we_n
);

    typedef enum logic [2:0] {
        IDLE, LO_SETUP, LO_STB, HI_SETUP, HI_STB, ACK
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;

    // request captured in IDLE
    logic [ADR_W-2:0] adr_q;
    logic [31:0]      dat_q;
    logic [3:0]       sel_q;
    logic             we_q;
    logic             abort_q;
    logic [15:0]      rd_lo;

    logic             req, idle, stb_last, abort;

    // request as seen this cycle: live bus inputs while latching, else the copy
    logic [ADR_W-2:0] r_adr;
    logic [31:0]      r_dat;
    logic [3:0]       r_sel;
    logic             r_we;

    // next values of the registered outputs
    logic             hi_nxt, acc_nxt, strobe_nxt;
    logic [ADR_W-1:0] adr_d;
    logic [15:0]      dout_d;
    logic [1:0]       be_d;
    logic             ce_d, oe_d, we_d, doe_d, ack_d;
    logic [31:0]      rdat_d;

    // address bits outside the SRAM window alias by design
    logic             unused_adr_bits;
    assign unused_adr_bits = ^{wb_adr_i[31:ADR_W+1], wb_adr_i[1:0]};

    assign req      = wb_cyc_i & wb_stb_i;
    assign idle     = (state == IDLE);
    assign stb_last = (cnt == CNT_LAST);
    // a dropped cyc/stb anywhere in the access cancels the remaining half
    assign abort    = abort_q | ~req;

    assign r_adr = idle ? wb_adr_i[ADR_W:2] : adr_q;
    assign r_dat = idle ? wb_dat_i : dat_q;
    assign r_sel = idle ? wb_sel_i : sel_q;
    assign r_we  = idle ? wb_we_i  : we_q;

    // next-state and strobe counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (wb_sel_i[1:0] != 2'b00)      state_nxt = LO_SETUP;
                    else if (wb_sel_i[3:2] != 2'b00) state_nxt = HI_SETUP;
                    else                             state_nxt = ACK;
                end
            end
            LO_SETUP: state_nxt = LO_STB;
            LO_STB: begin
                if (!stb_last)                 cnt_nxt   = cnt + 4'd1;
                else if (abort)                state_nxt = IDLE;
                else if (sel_q[3:2] != 2'b00)  state_nxt = HI_SETUP;
                else                           state_nxt = ACK;
            end
            HI_SETUP: state_nxt = HI_STB;
            HI_STB: begin
                if (!stb_last)   cnt_nxt   = cnt + 4'd1;
                else if (abort)  state_nxt = IDLE;
                else             state_nxt = ACK;
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // output values for the state being entered; address/be/data hold when idle
    always_comb begin
        hi_nxt     = (state_nxt == HI_SETUP) || (state_nxt == HI_STB);
        acc_nxt    = (state_nxt == LO_SETUP) || (state_nxt == LO_STB) || hi_nxt;
        strobe_nxt = (state_nxt == LO_STB) || (state_nxt == HI_STB);
        adr_d  = sram_adr;
        dout_d = sram_dat_o;
        be_d   = sram_be_n;
        ce_d   = 1'b1;
        oe_d   = 1'b1;
        we_d   = 1'b1;
        doe_d  = 1'b0;
        ack_d  = (state_nxt == ACK);
        rdat_d = wb_dat_o;
        if (acc_nxt) begin
            adr_d = {r_adr, hi_nxt};
            be_d  = hi_nxt ? ~r_sel[3:2] : ~r_sel[1:0];
            ce_d  = 1'b0;
            oe_d  = r_we;
            doe_d = r_we;
            we_d  = ~(r_we & strobe_nxt);
            if (r_we) dout_d = hi_nxt ? r_dat[31:16] : r_dat[15:0];
        end
        // read data is published on entry to ACK; skipped halves read zero
        if (state_nxt == ACK && !r_we) begin
            case (state)
                LO_STB:  rdat_d = {16'h0000, sram_dat_i};
                HI_STB:  rdat_d = {sram_dat_i, rd_lo};
                default: rdat_d = 32'h0;
            endcase
        end
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            wb_ack_o    <= 1'b0;
            wb_dat_o    <= '0;
            sram_adr    <= '0;
            sram_dat_o  <= '0;
            sram_dat_oe <= 1'b0;
            sram_be_n   <= 2'b11;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            wb_ack_o    <= ack_d;
            wb_dat_o    <= rdat_d;
            sram_adr    <= adr_d;
            sram_dat_o  <= dout_d;
            sram_dat_oe <= doe_d;
            sram_be_n   <= be_d;
            sram_ce_n   <= ce_d;
            sram_oe_n   <= oe_d;
            sram_we_n   <= we_d;
        end
    end

    // capture the bus request when IDLE accepts it
    always_ff @(posedge clk) begin
        if (idle && req) begin
            adr_q <= wb_adr_i[ADR_W:2];
            dat_q <= wb_dat_i;
            sel_q <= wb_sel_i;
            we_q  <= wb_we_i;
        end
    end

    // sticky cancel flag and low-half read staging
    always_ff @(posedge clk) begin
        if (rst) begin
            abort_q <= 1'b0;
            rd_lo   <= '0;
        end else begin
            if (idle)      abort_q <= 1'b0;
            else if (!req) abort_q <= 1'b1;
            if (idle && req)
                rd_lo <= '0;
            else if (state == LO_STB && stb_last && !we_q)
                rd_lo <= sram_dat_i;
        end
    end

endmodule

// File: tb/tb_wb_sram16_bridge.sv
// Bench for wb_sram16_bridge: two instances (WAIT_CYCLES 1 and 3) share a
// behavioural SRAM; expected acks are queued per request and popped on ack.
module tb_wb_sram16_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr = '0, dat = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
    logic        use3 = 1'b0;
    logic [15:0] sram_rd = 16'hC0DE;

    always #5 clk = ~clk;

    logic [31:0] dat_o1, dat_o3;
    logic        ack1, ack3;
    logic [18:0] adr1, adr3;
    logic [15:0] do1, do3;
    logic        doe1, doe3, ce1, ce3, oe1, oe3, we1, we3;
    logic [1:0]  be1, be3;

    wb_sram16_bridge #(.ADR_W(19), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat_o1),
        .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb & ~use3), .wb_cyc_i(cyc & ~use3),
        .wb_ack_o(ack1), .sram_adr(adr1), .sram_dat_o(do1), .sram_dat_i(sram_rd),
        .sram_dat_oe(doe1), .sram_be_n(be1), .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1));

    wb_sram16_bridge #(.ADR_W(19), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat_o3),
        .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb & use3), .wb_cyc_i(cyc & use3),
        .wb_ack_o(ack3), .sram_adr(adr3), .sram_dat_o(do3), .sram_dat_i(sram_rd),
        .sram_dat_oe(doe3), .sram_be_n(be3), .sram_ce_n(ce3), .sram_oe_n(oe3), .sram_we_n(we3));

    logic [31:0] s_dat_o;
    logic        s_ack, s_doe, s_ce_n, s_oe_n, s_we_n;
    logic [18:0] s_adr;
    logic [15:0] s_dout;
    logic [1:0]  s_be_n;
    assign s_dat_o = use3 ? dat_o3 : dat_o1;
    assign s_ack   = use3 ? ack3 : ack1;
    assign s_adr   = use3 ? adr3 : adr1;
    assign s_dout  = use3 ? do3 : do1;
    assign s_doe   = use3 ? doe3 : doe1;
    assign s_be_n  = use3 ? be3 : be1;
    assign s_ce_n  = use3 ? ce3 : ce1;
    assign s_oe_n  = use3 ? oe3 : oe1;
    assign s_we_n  = use3 ? we3 : we1;

    // SRAM model and pin activity monitor
    logic [15:0] mem [0:(1<<19)-1];
    int          we_run = 0, oe_low = 0, ce_low = 0, doe_cnt = 0;
    logic [18:0] pa_q[$];
    logic [1:0]  pb_q[$];
    int          pw_q[$];

    always @(negedge clk) begin
        if (!s_ce_n && !s_we_n && s_doe) begin
            if (!s_be_n[0]) mem[s_adr][7:0]  <= s_dout[7:0];
            if (!s_be_n[1]) mem[s_adr][15:8] <= s_dout[15:8];
        end
        if (!s_we_n) begin
            if (we_run == 0) begin
                pa_q.push_back(s_adr);
                pb_q.push_back(s_be_n);
            end
            we_run <= we_run + 1;
        end else if (we_run != 0) begin
            pw_q.push_back(we_run);
            we_run <= 0;
        end
        oe_low  <= oe_low  + (s_oe_n ? 0 : 1);
        ce_low  <= ce_low  + (s_ce_n ? 0 : 1);
        doe_cnt <= doe_cnt + (s_doe ? 1 : 0);
        sram_rd <= (!s_ce_n && !s_oe_n) ? mem[s_adr] : 16'hC0DE;
    end

    typedef struct {
        int          lat;
        logic        we;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    int nchk = 0, nerr = 0;

    function automatic logic [31:0] rd_exp(input logic [31:0] a, input logic [3:0] s);
        logic [15:0] lo, hi;
        lo = (s[1:0] != 2'b00) ? mem[{a[19:2], 1'b0}] : 16'h0000;
        hi = (s[3:2] != 2'b00) ? mem[{a[19:2], 1'b1}] : 16'h0000;
        return {hi, lo};
    endfunction

    // One bus access; drop_at>0 drops cyc/stb in that cycle and expects no ack.
    // Cycle 1 is the cycle right after the latching edge.
    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic w, input int drop_at);
        exp_t e, g;
        int   h;
        bit   got;
        h = ((s[1:0] != 2'b00) ? 1 : 0) + ((s[3:2] != 2'b00) ? 1 : 0);
        e.lat   = 1 + h * (1 + (use3 ? 3 : 1));
        e.we    = w;
        e.rdata = rd_exp(a, s);
        if (drop_at == 0) sb.push_back(e);
        @(negedge clk);
        adr = a; dat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        got = 1'b0;
        for (int n = 1; n <= 30 && !got; n++) begin
            @(negedge clk);
            if (n == drop_at) begin cyc = 1'b0; stb = 1'b0; end
            if (s_ack) begin
                got = 1'b1;
                cyc = 1'b0; stb = 1'b0;
                if (sb.size() != 0) begin
                    g = sb.pop_front();
                    nchk++;
                    if (n != g.lat) begin
                        nerr++;
                        $display("FAIL ack_latency adr=%h: ack in cycle %0d, required %0d", a, n, g.lat);
                    end
                    if (!g.we) begin
                        nchk++;
                        if (s_dat_o !== g.rdata) begin
                            nerr++;
                            $display("FAIL read_data adr=%h: got %h, required %h", a, s_dat_o, g.rdata);
                        end
                    end
                end
            end
        end
        nchk++;
        if (drop_at == 0 && !got) begin
            nerr++;
            $display("FAIL ack_timeout adr=%h: no ack within 30 cycles", a);
        end else if (drop_at != 0 && got) begin
            nerr++;
            $display("FAIL aborted_ack adr=%h: ack seen, required none", a);
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        nchk++;
        if (s_ack !== 1'b0) begin nerr++; $display("FAIL reset_ack: got %b, required 0", s_ack); end
        nchk++;
        if (s_dat_o !== 32'h0) begin nerr++; $display("FAIL reset_dat_o: got %h, required 0", s_dat_o); end
        nchk++;
        if (s_adr !== 19'h0 || s_dout !== 16'h0) begin
            nerr++; $display("FAIL reset_adr_dout: got %h/%h, required 0/0", s_adr, s_dout);
        end
        nchk++;
        if ({s_doe, s_be_n, s_ce_n, s_oe_n, s_we_n} !== 6'b011111) begin
            nerr++; $display("FAIL reset_ctrl: got %b, required 011111", {s_doe, s_be_n, s_ce_n, s_oe_n, s_we_n});
        end
        rst = 1'b0;
    endtask

    task automatic test_word_write();
        int p0, w0;
        p0 = pa_q.size(); w0 = pw_q.size();
        xfer(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 0);
        @(negedge clk);
        nchk++;
        if (mem[19'h8] !== 16'hBEEF || mem[19'h9] !== 16'hDEAD) begin
            nerr++; $display("FAIL ww_mem: got %h/%h, required beef/dead", mem[19'h8], mem[19'h9]);
        end
        nchk++;
        if (pa_q.size() - p0 != 2) begin
            nerr++; $display("FAIL ww_pulses: got %0d we pulses, required 2", pa_q.size() - p0);
        end else begin
            nchk++;
            if (pa_q[p0] !== 19'h8 || pa_q[p0+1] !== 19'h9) begin
                nerr++; $display("FAIL ww_order: got %h,%h, required 8,9", pa_q[p0], pa_q[p0+1]);
            end
            nchk++;
            if (pb_q[p0] !== 2'b00 || pb_q[p0+1] !== 2'b00) begin
                nerr++; $display("FAIL ww_be: got %b,%b, required 00,00", pb_q[p0], pb_q[p0+1]);
            end
        end
        nchk++;
        if (pw_q.size() - w0 != 2 || pw_q[w0] != 1 || pw_q[w0+1] != 1) begin
            nerr++; $display("FAIL ww_width: got %0d pulses, required 2 of width 1", pw_q.size() - w0);
        end
    endtask

    task automatic test_word_read();
        int o0, d0;
        o0 = oe_low; d0 = doe_cnt;
        xfer(32'h0000_0010, 32'h0, 4'hF, 1'b0, 0);
        @(negedge clk);
        nchk++;
        if (oe_low - o0 != 4) begin nerr++; $display("FAIL wr_oe_cycles: got %0d, required 4", oe_low - o0); end
        nchk++;
        if (doe_cnt - d0 != 0) begin nerr++; $display("FAIL wr_dat_oe: got %0d cycles, required 0", doe_cnt - d0); end
    endtask

    task automatic test_byte_write();
        int p0;
        xfer(32'h0000_0020, 32'h5555_1234, 4'hF, 1'b1, 0);
        p0 = pa_q.size();
        xfer(32'h0000_0020, 32'h00AA_0000, 4'b0100, 1'b1, 0);
        @(negedge clk);
        nchk++;
        if (mem[19'h10] !== 16'h1234 || mem[19'h11] !== 16'h55AA) begin
            nerr++; $display("FAIL bw_mem: got %h/%h, required 1234/55aa", mem[19'h10], mem[19'h11]);
        end
        nchk++;
        if (pa_q.size() - p0 != 1) begin
            nerr++; $display("FAIL bw_pulses: got %0d, required 1", pa_q.size() - p0);
        end else begin
            nchk++;
            if (pa_q[p0] !== 19'h11 || pb_q[p0] !== 2'b10) begin
                nerr++; $display("FAIL bw_adr_be: got %h/%b, required 11/10", pa_q[p0], pb_q[p0]);
            end
        end
    endtask

    task automatic test_sel_zero();
        int c0;
        c0 = ce_low;
        xfer(32'h0000_0010, 32'h0, 4'h0, 1'b0, 0);
        @(negedge clk);
        nchk++;
        if (ce_low != c0) begin nerr++; $display("FAIL sel0_ce: got %0d ce cycles, required 0", ce_low - c0); end
    endtask

    task automatic test_back_to_back();
        xfer(32'h0000_0030, 32'h1357_9BDF, 4'hF, 1'b1, 0);
        xfer(32'h0000_0030, 32'h0, 4'hF, 1'b0, 0);
        xfer(32'h0000_0010, 32'h0, 4'b0011, 1'b0, 0);
        xfer(32'h0000_0010, 32'h0, 4'b1100, 1'b0, 0);
    endtask

    task automatic test_abort();
        int p0;
        xfer(32'h0000_0040, 32'hFFFF_FFFF, 4'hF, 1'b1, 0);
        p0 = pa_q.size();
        xfer(32'h0000_0040, 32'h1111_2222, 4'hF, 1'b1, 2);
        @(negedge clk);
        nchk++;
        if (mem[19'h20] !== 16'h2222 || mem[19'h21] !== 16'hFFFF) begin
            nerr++; $display("FAIL abort_mem: got %h/%h, required 2222/ffff", mem[19'h20], mem[19'h21]);
        end
        nchk++;
        if (pa_q.size() - p0 != 1) begin nerr++; $display("FAIL abort_pulses: got %0d, required 1", pa_q.size() - p0); end
        nchk++;
        if (s_ce_n !== 1'b1) begin nerr++; $display("FAIL abort_idle: ce_n=%b, required 1", s_ce_n); end
        xfer(32'h0000_0040, 32'h0, 4'hF, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        adr = 32'h0000_0050; dat = 32'hCAFE_F00D; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        for (int n = 1; n <= 4; n++) @(negedge clk);
        nchk++;
        if (s_we_n !== 1'b0 || s_adr !== 19'h29) begin
            nerr++; $display("FAIL rm_hi_stb: we_n=%b adr=%h, required 0/29", s_we_n, s_adr);
        end
        rst = 1'b1;
        @(negedge clk);
        nchk++;
        if ({s_ack, s_doe, s_ce_n, s_oe_n, s_we_n} !== 5'b00111) begin
            nerr++; $display("FAIL rm_ctrl: got %b, required 00111", {s_ack, s_doe, s_ce_n, s_oe_n, s_we_n});
        end
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        xfer(32'h0000_0010, 32'h0, 4'hF, 1'b0, 0);
    endtask

    task automatic test_wrap();
        int p0;
        p0 = pa_q.size();
        xfer(32'h001F_FFFC, 32'h0BAD_F00D, 4'hF, 1'b1, 0);
        @(negedge clk);
        nchk++;
        if (pa_q.size() - p0 != 2 || pa_q[p0] !== 19'h7FFFE || pa_q[p0+1] !== 19'h7FFFF) begin
            nerr++; $display("FAIL wrap_adr: got %0d pulses, required halves 7fffe,7ffff", pa_q.size() - p0);
        end
        nchk++;
        if (mem[19'h7FFFE] !== 16'hF00D) begin nerr++; $display("FAIL wrap_mem: got %h, required f00d", mem[19'h7FFFE]); end
        xfer(32'h003F_FFFC, 32'h0, 4'hF, 1'b0, 0);
    endtask

    task automatic test_wait3();
        int w0, o0;
        use3 = 1'b1;
        w0 = pw_q.size();
        xfer(32'h0000_0060, 32'h600D_CAFE, 4'hF, 1'b1, 0);
        @(negedge clk);
        nchk++;
        if (pw_q.size() - w0 != 2 || pw_q[w0] != 3 || pw_q[w0+1] != 3) begin
            nerr++; $display("FAIL w3_we_width: got %0d pulses, required 2 of width 3", pw_q.size() - w0);
        end
        o0 = oe_low;
        xfer(32'h0000_0060, 32'h0, 4'hF, 1'b0, 0);
        @(negedge clk);
        nchk++;
        if (oe_low - o0 != 8) begin nerr++; $display("FAIL w3_oe_cycles: got %0d, required 8", oe_low - o0); end
        use3 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_word_read();
        test_byte_write();
        test_sel_zero();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_wrap();
        test_wait3();
        nchk++;
        if (sb.size() != 0) begin nerr++; $display("FAIL scoreboard_left: %0d acks outstanding", sb.size()); end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
